// File: rtl/text_readback_pkg.sv
`default_nettype none
// ============================================================================
// Module  : text_readback_pkg
// Purpose : Shared types and constants for the text memory readback block:
//           FSM state encoding, packet byte indices, default address width
//           and a helper that picks one byte of an outgoing packet.
// Rev     : 1.0  initial release
// ============================================================================
package text_readback_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_LATCH     = 3'd2,
    ST_SEND_LO   = 3'd3,
    ST_SEND_HI   = 3'd4,
    ST_SEND_CHAR = 3'd5,
    ST_GAP       = 3'd6,
    ST_DONE      = 3'd7
  } state_t;

  // Byte order inside one packet, identical to the UART write path.
  localparam int PKT_ADDR_LO = 0;
  localparam int PKT_ADDR_HI = 1;
  localparam int PKT_CHAR    = 2;
  localparam int PKT_BYTES   = 3;

  localparam int DEFAULT_ADDR_WIDTH = 13;

  // Select byte 'idx' of the packet for a 16-bit zero-extended address.
  function automatic logic [7:0] pkt_byte(input logic [15:0] addr16,
                                          input logic [7:0]  ch,
                                          input int          idx);
    case (idx)
      PKT_ADDR_LO: return addr16[7:0];
      PKT_ADDR_HI: return addr16[15:8];
      default:     return ch;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/text_readback_gap_timer.sv
`default_nettype none
// ============================================================================
// Module  : readback_gap_timer
// Purpose : Load / count-down timer. 'expired' is high while the count is 0.
//           Loading takes priority over counting; the count holds at 0.
// Ports   : clock, reset      - clock, synchronous active-high reset
//           load, load_value  - reload the counter
//           expired           - counter has reached zero
// Rev     : 1.0  initial release
// ============================================================================
module readback_gap_timer #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_value,
  output logic                   expired
);

  logic [COUNT_WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - COUNT_WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule
`default_nettype wire

// File: rtl/text_readback.sv
`default_nettype none
// ============================================================================
// Module  : text_readback
// Purpose : Streams characters from the text memory read port to the UART TX
//           byte interface as 3-byte packets (addr lo, addr hi, char), the
//           same format the UART write path accepts.
// Ports   : clock, reset                 - clock, synchronous active-high reset
//           start, start_address, length - request (sampled in IDLE only)
//           busy, done                   - status, done is a 1-cycle pulse
//           mem_address, mem_read,
//           mem_data                     - text memory read port (1-cycle latency)
//           tx_data, tx_valid, tx_ready  - UART TX byte handshake
// Config  : TEXT_READBACK_GAP_EN - when defined, idles GAP_CYCLES clocks
//           between packets (GAP state + readback_gap_timer).
// Rev     : 1.0  initial release
// ============================================================================
module text_readback
  import text_readback_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int GAP_CYCLES = 41_667
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_address,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  input  logic [7:0]            mem_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam logic [ADDR_WIDTH:0] REMAINING_LAST = (ADDR_WIDTH+1)'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [7:0]            char_q;
  logic [15:0]           addr_ext;
  logic                  gap_expired;

  assign addr_ext = 16'(addr);

`ifdef TEXT_READBACK_GAP_EN
  // Timer is loaded as the last byte of a non-final packet is accepted, so the
  // GAP state lasts exactly GAP_CYCLES clocks before the next READ.
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  logic gap_load;

  assign gap_load = (state == ST_SEND_CHAR) && tx_ready && (remaining != REMAINING_LAST);

  readback_gap_timer #(
    .COUNT_WIDTH (32)
  ) u_gap_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (gap_load),
    .load_value (32'(GAP_LOAD)),
    .expired    (gap_expired)
  );
`else
  assign gap_expired = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      char_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (length == '0) begin
              state <= ST_DONE;
            end else begin
              addr      <= start_address;
              remaining <= length;
              state     <= ST_READ;
            end
          end
        end
        ST_READ:  state <= ST_LATCH;
        ST_LATCH: begin
          char_q <= mem_data;
          state  <= ST_SEND_LO;
        end
        ST_SEND_LO: if (tx_ready) state <= ST_SEND_HI;
        ST_SEND_HI: if (tx_ready) state <= ST_SEND_CHAR;
        ST_SEND_CHAR: begin
          if (tx_ready) begin
            if (remaining == REMAINING_LAST) begin
              state <= ST_DONE;
            end else begin
              remaining <= remaining - REMAINING_LAST;
              addr      <= addr + ADDR_WIDTH'(1);  // wraps modulo 2^ADDR_WIDTH
`ifdef TEXT_READBACK_GAP_EN
              state     <= ST_GAP;
`else
              state     <= ST_READ;
`endif
            end
          end
        end
`ifdef TEXT_READBACK_GAP_EN
        ST_GAP: if (gap_expired) state <= ST_READ;
`endif
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state and registers; tx_ready never reaches
  // tx_valid combinationally, and tx_data only changes on a state change.
  always_comb begin
    busy        = (state != ST_IDLE);
    done        = (state == ST_DONE);
    mem_read    = (state == ST_READ);
    mem_address = addr;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    case (state)
      ST_SEND_LO: begin
        tx_valid = 1'b1;
        tx_data  = pkt_byte(addr_ext, char_q, PKT_ADDR_LO);
      end
      ST_SEND_HI: begin
        tx_valid = 1'b1;
        tx_data  = pkt_byte(addr_ext, char_q, PKT_ADDR_HI);
      end
      ST_SEND_CHAR: begin
        tx_valid = 1'b1;
        tx_data  = pkt_byte(addr_ext, char_q, PKT_CHAR);
      end
      default: begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
    endcase
  end

  // Only consulted in the GAP build; keeps the default build free of dangling
  // signals.
  logic unused_ok;
  assign unused_ok = gap_expired;

endmodule
`default_nettype wire

// File: tb/tb_text_readback.sv
`default_nettype none
// ============================================================================
// Module  : tb_text_readback
// Purpose : Self-checking bench for text_readback: table of directed requests
//           plus hand-written sequences for stall, restart and reset cases.
// Rev     : 1.0  initial release
// ============================================================================
module tb_text_readback;

  localparam int AW  = 13;
  localparam int GAP = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_address = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, mem_read, tx_valid;
  logic [AW-1:0] mem_address;
  logic [7:0]    mem_data = 8'h00;
  logic [7:0]    tx_data;
  logic          tx_ready = 1'b0;

  always #5 clock = ~clock;

  text_readback #(
    .ADDR_WIDTH (AW),
    .GAP_CYCLES (GAP)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .start_address (start_address),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .mem_address   (mem_address),
    .mem_read      (mem_read),
    .mem_data      (mem_data),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready)
  );

  // Text memory model with one cycle of read latency.
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clock) if (mem_read) mem_data <= mem[mem_address];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // tx_ready driver: constant level or random, updated just after each edge.
  bit   rnd_mode  = 1'b0;
  logic rdy_level = 1'b1;
  initial begin
    forever begin
      @(posedge clock);
      #1;
      tx_ready = rnd_mode ? 1'($urandom_range(0, 1)) : rdy_level;
    end
  end

  // Monitor samples mid-cycle.
  logic [7:0] got[$];
  int   done_cnt, done_cyc, rd_cnt, valid_cnt, last_cyc, rd2_cyc;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if (!tx_valid || tx_data !== prev_data) begin
          bad++;
          $display("FAIL stall_hold: got valid=%0b data=%0h expected valid=1 data=%0h",
                   tx_valid, tx_data, prev_data);
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        if (got.size() == 3 && last_cyc < 0) last_cyc = cyc;
      end
      if (mem_read) begin
        rd_cnt++;
        if (last_cyc >= 0 && rd2_cyc < 0) rd2_cyc = cyc;
      end
      if (tx_valid) valid_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  function automatic int gap_adj(input int n);
`ifdef TEXT_READBACK_GAP_EN
    return (n > 1) ? (n - 1) * GAP : 0;
`else
    return 0;
`endif
  endfunction

  task automatic clear_mon();
    got.delete();
    done_cnt = 0; done_cyc = -1; rd_cnt = 0; valid_cnt = 0;
    last_cyc = -1; rd2_cyc = -1;
  endtask

  // Issue a request, wait (bounded) for done, return done's cycle number
  // counted from the start cycle (cycle 0).
  task automatic run_req(input logic [AW-1:0] a, input logic [AW:0] n,
                         input int budget, output int rel);
    int acc;
    clear_mon();
    @(negedge clock);
    start = 1'b1; start_address = a; length = n;
    @(posedge clock);
    #1;
    acc = cyc;
    start = 1'b0; start_address = '1; length = '1;  // must not be resampled
    for (int i = 0; i < budget; i++) begin
      @(posedge clock);
      #2;
      if (done_cnt > 0) break;
    end
    chk("done_seen", 32'(done_cnt > 0), 32'd1);
    rel = (done_cnt > 0) ? done_cyc - acc + 1 : -1;
    repeat (3) @(posedge clock);
    #2;
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_single", 32'(done_cnt), 32'd1);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [AW:0]   len;
    bit            rnd;
    int            exp_done;    // -1: timing not fixed for this vector
    int            exp_nbytes;
  } vec_t;

  vec_t vecs[5];
  logic [7:0] exp_q[$];

  initial begin
    int rel;
    logic [AW-1:0] a;
    logic [15:0]   a16;
    bit found;

    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[13'h0100] = 8'h41;
    mem[13'h1FFE] = 8'h41;
    mem[13'h1FFF] = 8'h42;
    mem[13'h0000] = 8'h43;

    vecs[0] = '{13'h0100, 14'd1,  1'b0,  6 + gap_adj(1), 3};
    vecs[1] = '{13'h1FFE, 14'd3,  1'b0, 16 + gap_adj(3), 9};
    vecs[2] = '{13'h0AAA, 14'd2,  1'b0, 11 + gap_adj(2), 6};
    vecs[3] = '{13'h0123, 14'd16, 1'b1, -1,             48};
    vecs[4] = '{13'h1FF0, 14'd4,  1'b1, -1,             12};

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", {busy, done, mem_read, tx_valid, 3'b0, mem_address, tx_data},
        32'd0);
    reset = 1'b0;
    clear_mon();

    for (int v = 0; v < 5; v++) begin
      rnd_mode  = vecs[v].rnd;
      rdy_level = 1'b1;
      run_req(vecs[v].addr, vecs[v].len, 2000, rel);
      rnd_mode = 1'b0;
      if (vecs[v].exp_done >= 0)
        chk($sformatf("v%0d_done_cycle", v), 32'(rel), 32'(vecs[v].exp_done));
      chk($sformatf("v%0d_nbytes", v), 32'(got.size()), 32'(vecs[v].exp_nbytes));
      exp_q.delete();
      for (int k = 0; k < int'(vecs[v].len); k++) begin
        a   = vecs[v].addr + AW'(k);
        a16 = 16'(a);
        exp_q.push_back(a16[7:0]);
        exp_q.push_back(a16[15:8]);
        exp_q.push_back(mem[a]);
      end
      for (int k = 0; k < exp_q.size() && k < got.size(); k++)
        chk($sformatf("v%0d_byte%0d", v, k), 32'(got[k]), 32'(exp_q[k]));
      if (v == 1) begin
        // Hand-written wrap stream.
        exp_q = '{8'hFE, 8'h1F, 8'h41, 8'hFF, 8'h1F, 8'h42, 8'h00, 8'h00, 8'h43};
        for (int k = 0; k < 9 && k < got.size(); k++)
          chk($sformatf("wrap_byte%0d", k), 32'(got[k]), 32'(exp_q[k]));
      end
      if (v == 0) begin
        chk("single_stream", {8'h0, got[0], got[1], got[2]}, 32'h00000141);
      end
    end

    // Zero length: no read, no bytes, done soon after start.
    run_req(13'h0200, 14'd0, 20, rel);
    chk("len0_reads", 32'(rd_cnt), 32'd0);
    chk("len0_valid", 32'(valid_cnt), 32'd0);
    chk("len0_done_early", 32'(rel >= 1 && rel <= 2), 32'd1);

    // Restart while busy is ignored; reset in SEND_HI aborts cleanly.
    clear_mon();
    rdy_level = 1'b1;
    @(negedge clock);
    start = 1'b1; start_address = 13'h0200; length = 14'd4;
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock); #1;
    start = 1'b1; start_address = 13'h0333; length = 14'd5;
    @(posedge clock); #1; start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (tx_valid && tx_data == 8'h02) begin
        found = 1'b1;
        break;
      end
    end
    chk("reached_send_hi", 32'(found), 32'd1);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (20) @(posedge clock);
    #2;
    chk("rst_no_done", 32'(done_cnt), 32'd0);
    chk("rst_nbytes", 32'(got.size()), 32'd2);
    if (got.size() >= 2) chk("rst_bytes", {16'h0, got[0], got[1]}, 32'h00000002);
    chk("rst_idle", {30'd0, busy, tx_valid}, 32'd0);

`ifdef TEXT_READBACK_GAP_EN
    run_req(13'h0500, 14'd2, 200, rel);
    chk("gap_spacing", 32'(rd2_cyc - last_cyc), 32'd11);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
